apb_fsm_controller: RTL and testbench
=====================================

APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

Interface
REQ-001 SHALL have port Hclk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port Hreset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port valid  in  1  qualified AHB transfer to the APB window, this cycle.
REQ-004 SHALL have port Hwrite  in  1  current AHB direction (1 = write).
REQ-005 SHALL have port Hwritereg  in  1  Hwrite delayed one cycle.
REQ-006 SHALL have ports Haddr, Haddr1, Haddr2  in  32  AHB address: current, 1-cycle delayed, 2-cycle delayed.
REQ-007 SHALL have ports Hwdata, Hwdata1  in  32  AHB write data: current, 1-cycle delayed.
REQ-008 SHALL have port tempselx  in  3  one-hot slave decode of current Haddr (001/010/100, 000 = none).
REQ-009 SHALL have port Pselx  out  3  APB slave select, registered.
REQ-010 SHALL have port Penable  out  1  APB enable phase, registered.
REQ-011 SHALL have port Pwrite  out  1  APB direction, registered.
REQ-012 SHALL have ports Paddr, Pwdata  out  32  APB address and write data, registered.
REQ-013 SHALL have port Hreadyout  out  1  AHB ready to master, registered (0 = wait state).

Function
REQ-014 SHALL implement states IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.
REQ-015 IDLE, RENABLE, WENABLE SHALL go to: WWAIT if valid&Hwrite; READ if valid&!Hwrite; else IDLE.
REQ-016 READ SHALL go to RENABLE unconditionally.
REQ-017 WWAIT SHALL go to WRITEP if valid, else WRITE.
REQ-018 WRITE SHALL go to WENABLEP if valid, else WENABLE.
REQ-019 WRITEP SHALL go to WENABLEP unconditionally.
REQ-020 WENABLEP SHALL go to: READ if !Hwritereg; WRITEP if valid&Hwritereg; WRITE if !valid&Hwritereg.
REQ-021 SHALL hold internal registers selx1 and selx2 tracking tempselx delayed 1 and 2 cycles (cleared to 000 by reset).
REQ-022 Entering READ SHALL load Paddr<=Haddr, Pselx<=tempselx, Pwrite<=0, Penable<=0.
REQ-023 Entering WRITE or WRITEP from WWAIT SHALL load Paddr<=Haddr1, Pwdata<=Hwdata, Pselx<=selx1, Pwrite<=1, Penable<=0.
REQ-024 Entering WRITE or WRITEP from WENABLEP SHALL load Paddr<=Haddr2, Pwdata<=Hwdata1, Pselx<=selx2, Pwrite<=1, Penable<=0.
REQ-025 Entering RENABLE, WENABLE, WENABLEP SHALL set Penable<=1 and hold Pselx, Paddr, Pwdata, Pwrite.
REQ-026 Entering IDLE or WWAIT SHALL set Pselx<=000, Penable<=0; Paddr, Pwdata, Pwrite hold.
REQ-027 Hreadyout SHALL be registered as 0 when next state is READ or WRITEP, else 1.
REQ-028 Latency: read = 2 APB cycles (READ, RENABLE) after valid; single write = 3 cycles (WWAIT, WRITE, WENABLE).
REQ-029 Back-to-back writes SHALL alternate WRITEP/WENABLEP with Hreadyout low for one cycle per transfer.
REQ-030 Write followed immediately by read SHALL complete the pending write (WENABLEP) before READ.
REQ-031 valid with tempselx=000 SHALL NOT occur (guaranteed upstream); no error response is generated.

Reset
REQ-032 Hreset=1 at a clock edge SHALL force state IDLE, Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, selx1=selx2=000.
REQ-033 Reset mid-transfer SHALL abandon the APB transfer without completing the enable phase; first post-reset cycle samples valid from IDLE.

Structure
REQ-034 State enum, APB address-window constants (0x8000_0000..0x8C00_0000) and select encodings SHALL live in shared package ahb2apb_pkg.
REQ-035 SHALL be a single module with no sub-module; next-state and output-register logic in separate processes.

Verification
REQ-036 Single read: valid=1, Hwrite=0, Haddr=0x8000_0010, tempselx=001 -> next cycle Pselx=001, Paddr=0x8000_0010, Penable=0, Hreadyout=0; following cycle Penable=1, Hreadyout=1.
REQ-037 Single write: Haddr=0x8400_0020, tempselx=010 then Hwdata=0xDEAD_BEEF, valid=0 -> WWAIT, WRITE (Paddr=0x8400_0020, Pwdata=0xDEAD_BEEF, Pwrite=1, Pselx=010), WENABLE (Penable=1), IDLE.
REQ-038 Back-to-back writes to 0x8800_0000 and 0x8800_0004 -> states WWAIT, WRITEP, WENABLEP, WRITE, WENABLE; Paddr order 0x8800_0000 then 0x8800_0004; Pselx=100 throughout.
REQ-039 Write then read (0x8000_0008 write, 0x8400_0000 read) -> WENABLEP completes write, then READ with Paddr=0x8400_0000, Pwrite=0, Pselx=010.
REQ-040 Hreset=1 while in WRITE -> next cycle IDLE, all outputs at reset values, Hreadyout=1.
REQ-041 valid held 0 for 10 cycles -> remains IDLE, Pselx=000, Penable=0, Hreadyout=1.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared AHB-to-APB bridge types: FSM state encoding, APB window bounds, slave selects.
// No logic; no latency; no backpressure.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WWAIT    = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        WRITEP   = 3'd4,
        RENABLE  = 3'd5,
        WENABLE  = 3'd6,
        WENABLEP = 3'd7
    } state_t;

    localparam logic [31:0] APB_WIN_LO = 32'h8000_0000;
    localparam logic [31:0] APB_WIN_HI = 32'h8C00_0000;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_S0   = 3'b001;
    localparam logic [2:0] SEL_S1   = 3'b010;
    localparam logic [2:0] SEL_S2   = 3'b100;

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge controller: sequences APB setup/enable phases from qualified AHB transfers.
// Latency: read 2 cycles (READ, RENABLE); single write 3 cycles (WWAIT, WRITE, WENABLE).
// Backpressure: Hreadyout drops for one cycle whenever the next state is READ or WRITEP.
module apb_fsm_controller
    import ahb2apb_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic        Hwritereg,
    input  logic [31:0] Haddr,
    input  logic [31:0] Haddr1,
    input  logic [31:0] Haddr2,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Hwdata1,
    input  logic [2:0]  tempselx,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout
);

    state_t     state;
    state_t     next_state;
    logic [2:0] selx1;
    logic [2:0] selx2;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, RENABLE, WENABLE: begin
                if (valid && Hwrite)       next_state = WWAIT;
                else if (valid && !Hwrite) next_state = READ;
                else                       next_state = IDLE;
            end
            READ:    next_state = RENABLE;
            WWAIT:   next_state = valid ? WRITEP : WRITE;
            WRITE:   next_state = valid ? WENABLEP : WENABLE;
            WRITEP:  next_state = WENABLEP;
            WENABLEP: begin
                if (!Hwritereg) next_state = READ;
                else if (valid) next_state = WRITEP;
                else            next_state = WRITE;
            end
            default: next_state = IDLE;
        endcase
    end

    // APB outputs are registered on the transition into next_state.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            selx1     <= SEL_NONE;
            selx2     <= SEL_NONE;
            Pselx     <= SEL_NONE;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            selx1     <= tempselx;
            selx2     <= selx1;
            Hreadyout <= !((next_state == READ) || (next_state == WRITEP));
            case (next_state)
                READ: begin
                    Paddr   <= Haddr;
                    Pselx   <= tempselx;
                    Pwrite  <= 1'b0;
                    Penable <= 1'b0;
                end
                WRITE, WRITEP: begin
                    // From WENABLEP the pending write sits one stage deeper in the AHB pipeline.
                    if (state == WENABLEP) begin
                        Paddr  <= Haddr2;
                        Pwdata <= Hwdata1;
                        Pselx  <= selx2;
                    end else begin
                        Paddr  <= Haddr1;
                        Pwdata <= Hwdata;
                        Pselx  <= selx1;
                    end
                    Pwrite  <= 1'b1;
                    Penable <= 1'b0;
                end
                RENABLE, WENABLE, WENABLEP: begin
                    Penable <= 1'b1;
                end
                default: begin
                    Pselx   <= SEL_NONE;
                    Penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller; AHB delay pipeline for Haddr1/2, Hwdata1, Hwritereg built here.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        valid;
    logic        Hwrite;
    logic        Hwritereg;
    logic [31:0] Haddr;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata;
    logic [31:0] Hwdata1;
    logic [2:0]  tempselx;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;

    int total = 0;
    int bad   = 0;

    always #5 Hclk = ~Hclk;

    // Models the AHB slave interface registers that feed the controller.
    always @(posedge Hclk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwdata1   <= Hwdata;
        Hwritereg <= Hwrite;
    end

    apb_fsm_controller dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Hwritereg (Hwritereg),
        .Haddr     (Haddr),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata    (Hwdata),
        .Hwdata1   (Hwdata1),
        .tempselx  (tempselx),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0;
        Haddr = 32'h0; Hwdata = 32'h0; tempselx = 3'b000;
        tick(); tick(); tick();
        total++; if (Pselx !== 3'b000)  begin bad++; $display("FAIL rst_pselx got=%b want=000", Pselx); end
        total++; if (Penable !== 1'b0)  begin bad++; $display("FAIL rst_penable got=%b want=0", Penable); end
        total++; if (Pwrite !== 1'b0)   begin bad++; $display("FAIL rst_pwrite got=%b want=0", Pwrite); end
        total++; if (Paddr !== 32'h0)   begin bad++; $display("FAIL rst_paddr got=%h want=0", Paddr); end
        total++; if (Pwdata !== 32'h0)  begin bad++; $display("FAIL rst_pwdata got=%h want=0", Pwdata); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hready got=%b want=1", Hreadyout); end
        Hreset = 1'b0;
        tick();
    endtask

    task automatic test_idle_hold();
        valid = 1'b0; Hwrite = 1'b0; tempselx = 3'b000;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got psel=%b pen=%b hrdy=%b want 000/0/1", i, Pselx, Penable, Hreadyout);
            end
        end
    endtask

    task automatic test_single_read();
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010; tempselx = 3'b001;
        tick();
        valid = 1'b0; tempselx = 3'b000;
        total++; if (Pselx !== 3'b001)       begin bad++; $display("FAIL rd_pselx got=%b want=001", Pselx); end
        total++; if (Paddr !== 32'h8000_0010) begin bad++; $display("FAIL rd_paddr got=%h want=80000010", Paddr); end
        total++; if (Penable !== 1'b0)       begin bad++; $display("FAIL rd_setup_pen got=%b want=0", Penable); end
        total++; if (Pwrite !== 1'b0)        begin bad++; $display("FAIL rd_pwrite got=%b want=0", Pwrite); end
        total++; if (Hreadyout !== 1'b0)     begin bad++; $display("FAIL rd_setup_hrdy got=%b want=0", Hreadyout); end
        tick();
        total++; if (Penable !== 1'b1)       begin bad++; $display("FAIL rd_enable_pen got=%b want=1", Penable); end
        total++; if (Hreadyout !== 1'b1)     begin bad++; $display("FAIL rd_enable_hrdy got=%b want=1", Hreadyout); end
        total++; if (Pselx !== 3'b001)       begin bad++; $display("FAIL rd_enable_psel got=%b want=001", Pselx); end
        tick();
        total++; if (Pselx !== 3'b000 || Penable !== 1'b0) begin bad++; $display("FAIL rd_idle got psel=%b pen=%b want 000/0", Pselx, Penable); end
    endtask

    task automatic test_single_write();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0020; tempselx = 3'b010;
        tick();
        total++; if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
            bad++; $display("FAIL wr_wwait got psel=%b pen=%b hrdy=%b want 000/0/1", Pselx, Penable, Hreadyout); end
        valid = 1'b0; Hwdata = 32'hDEAD_BEEF; Haddr = 32'h0; tempselx = 3'b000;
        tick();
        total++; if (Paddr !== 32'h8400_0020)  begin bad++; $display("FAIL wr_paddr got=%h want=84000020", Paddr); end
        total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_pwdata got=%h want=deadbeef", Pwdata); end
        total++; if (Pwrite !== 1'b1)          begin bad++; $display("FAIL wr_pwrite got=%b want=1", Pwrite); end
        total++; if (Pselx !== 3'b010)         begin bad++; $display("FAIL wr_pselx got=%b want=010", Pselx); end
        total++; if (Penable !== 1'b0 || Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_setup got pen=%b hrdy=%b want 0/1", Penable, Hreadyout); end
        tick();
        total++; if (Penable !== 1'b1 || Pselx !== 3'b010) begin bad++; $display("FAIL wr_enable got pen=%b psel=%b want 1/010", Penable, Pselx); end
        tick();
        total++; if (Pselx !== 3'b000 || Penable !== 1'b0 || Pwrite !== 1'b1) begin
            bad++; $display("FAIL wr_idle got psel=%b pen=%b pwr=%b want 000/0/1", Pselx, Penable, Pwrite); end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000; tempselx = 3'b100;
        tick();
        Haddr = 32'h8800_0004; Hwdata = 32'h1111_0000;
        tick();
        total++; if (Paddr !== 32'h8800_0000 || Pwdata !== 32'h1111_0000) begin
            bad++; $display("FAIL b2b_wp_addr got a=%h d=%h want 88000000/11110000", Paddr, Pwdata); end
        total++; if (Pselx !== 3'b100 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin
            bad++; $display("FAIL b2b_wp_ctl got psel=%b pen=%b hrdy=%b want 100/0/0", Pselx, Penable, Hreadyout); end
        valid = 1'b0; Hwdata = 32'h2222_0004; Haddr = 32'h0; tempselx = 3'b000;
        tick();
        total++; if (Penable !== 1'b1 || Pselx !== 3'b100 || Hreadyout !== 1'b1 || Paddr !== 32'h8800_0000) begin
            bad++; $display("FAIL b2b_wep got pen=%b psel=%b hrdy=%b a=%h want 1/100/1/88000000", Penable, Pselx, Hreadyout, Paddr); end
        Hwdata = 32'h0;
        tick();
        total++; if (Paddr !== 32'h8800_0004 || Pwdata !== 32'h2222_0004) begin
            bad++; $display("FAIL b2b_w_addr got a=%h d=%h want 88000004/22220004", Paddr, Pwdata); end
        total++; if (Pselx !== 3'b100 || Penable !== 1'b0 || Pwrite !== 1'b1) begin
            bad++; $display("FAIL b2b_w_ctl got psel=%b pen=%b pwr=%b want 100/0/1", Pselx, Penable, Pwrite); end
        tick();
        total++; if (Penable !== 1'b1 || Pselx !== 3'b100) begin bad++; $display("FAIL b2b_we got pen=%b psel=%b want 1/100", Penable, Pselx); end
        tick();
        total++; if (Pselx !== 3'b000) begin bad++; $display("FAIL b2b_idle got psel=%b want 000", Pselx); end
    endtask

    task automatic test_write_then_read();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0008; tempselx = 3'b001;
        tick();
        Hwrite = 1'b0; Haddr = 32'h8400_0000; tempselx = 3'b010; Hwdata = 32'hCAFE_0008;
        tick();
        total++; if (Paddr !== 32'h8000_0008 || Pwdata !== 32'hCAFE_0008 || Pselx !== 3'b001 || Pwrite !== 1'b1 || Hreadyout !== 1'b0) begin
            bad++; $display("FAIL wr_rd_wp got a=%h d=%h psel=%b pwr=%b hrdy=%b want 80000008/cafe0008/001/1/0", Paddr, Pwdata, Pselx, Pwrite, Hreadyout); end
        tick();
        total++; if (Penable !== 1'b1 || Pwrite !== 1'b1 || Pselx !== 3'b001 || Hreadyout !== 1'b1) begin
            bad++; $display("FAIL wr_rd_wep got pen=%b pwr=%b psel=%b hrdy=%b want 1/1/001/1", Penable, Pwrite, Pselx, Hreadyout); end
        valid = 1'b0;
        tick();
        total++; if (Paddr !== 32'h8400_0000 || Pwrite !== 1'b0 || Pselx !== 3'b010 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin
            bad++; $display("FAIL wr_rd_read got a=%h pwr=%b psel=%b pen=%b hrdy=%b want 84000000/0/010/0/0", Paddr, Pwrite, Pselx, Penable, Hreadyout); end
        tempselx = 3'b000; Haddr = 32'h0;
        tick();
        total++; if (Penable !== 1'b1 || Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_rd_renable got pen=%b hrdy=%b want 1/1", Penable, Hreadyout); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0040; tempselx = 3'b010;
        tick();
        valid = 1'b0; Hwdata = 32'h5A5A_A5A5; tempselx = 3'b000;
        tick();
        total++; if (Pselx !== 3'b010 || Paddr !== 32'h8400_0040) begin bad++; $display("FAIL rstw_write got psel=%b a=%h want 010/84000040", Pselx, Paddr); end
        Hreset = 1'b1;
        tick();
        total++; if (Pselx !== 3'b000 || Penable !== 1'b0 || Pwrite !== 1'b0 || Paddr !== 32'h0 || Pwdata !== 32'h0 || Hreadyout !== 1'b1) begin
            bad++; $display("FAIL rstw_vals got psel=%b pen=%b pwr=%b a=%h d=%h hrdy=%b want 000/0/0/0/0/1", Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout); end
        Hreset = 1'b0; valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0100; tempselx = 3'b100;
        tick();
        total++; if (Pselx !== 3'b100 || Paddr !== 32'h8800_0100 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin
            bad++; $display("FAIL rstw_read got psel=%b a=%h pen=%b hrdy=%b want 100/88000100/0/0", Pselx, Paddr, Penable, Hreadyout); end
        valid = 1'b0; tempselx = 3'b000;
        tick();
        total++; if (Penable !== 1'b1) begin bad++; $display("FAIL rstw_renable got pen=%b want 1", Penable); end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_write_then_read();
        test_reset_mid_write();
        test_idle_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
